// File: rtl/tinyvga_frame_monitor_if.sv
// Pin-level bundle between a TinyVGA source (master) and tinyvga_frame_monitor (slave).
// Carries the raw Pmod byte, the error-clear strobe and all monitor results.
interface tinyvga_frame_monitor_if;
   logic [7:0]  pix_in;
   logic        err_clr;
   logic        locked;
   logic        frame_done;
   logic [15:0] frame_crc;
   logic [15:0] frame_count;
   logic [11:0] h_len;
   logic [10:0] v_len;
   logic [1:0]  err;

   modport master (
      output pix_in, err_clr,
      input  locked, frame_done, frame_crc, frame_count, h_len, v_len, err
   );

   modport slave (
      input  pix_in, err_clr,
      output locked, frame_done, frame_crc, frame_count, h_len, v_len, err
   );
endinterface

// File: rtl/tinyvga_frame_monitor.sv
// Decodes TinyVGA Pmod sync/RGB, locks to line/frame timing and emits a CRC-16 per locked frame.
// Define MON_BLANK_CHECK_EN to flag non-zero RGB outside the active area while locked (err[1]).
module tinyvga_frame_monitor #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tinyvga_frame_monitor_if.slave mon
);
   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
   localparam logic [11:0] HA_FIRST  = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] HA_LAST   = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam logic [10:0] VA_FIRST  = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] VA_LAST   = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

   state_e      state_q, state_d;
   logic [7:0]  p_q, p_d;
   logic        hs_prev_q, hs_prev_d;
   logic        line_vs_q, line_vs_d;
   logic [11:0] hc_q, hc_d;
   logic [10:0] vc_q, vc_d;
   logic        line_ok_q, line_ok_d;
   logic [15:0] crc_q, crc_d;
   logic        locked_q, locked_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_crc_q, frame_crc_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic [11:0] h_len_q, h_len_d;
   logic [10:0] v_len_q, v_len_d;
   logic [1:0]  err_q, err_d;

   logic        hs_a, vs_a, hs_start, vs_start;
   logic [5:0]  rgb;
   logic [11:0] hc_inc;
   logic [10:0] vc_inc;
   logic        active, line_bad, frame_bad, hc_sat, crc_restart;
   logic [15:0] crc_base;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic [7:0]  dat;
      logic        fb;
      r   = c;
      dat = d;
      for (int unsigned i = 0; i < 8; i++) begin
         fb  = r[15] ^ dat[7];
         r   = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         dat = {dat[6:0], 1'b0};
      end
      return r;
   endfunction

   always_comb begin
      hs_a     = ~p_q[7];
      vs_a     = ~p_q[3];
      rgb      = {p_q[0], p_q[4], p_q[1], p_q[5], p_q[2], p_q[6]};
      hs_start = hs_a & ~hs_prev_q;
      vs_start = hs_start & vs_a & ~line_vs_q;
      hc_inc   = (hc_q == '1) ? hc_q : hc_q + 12'd1;
      vc_inc   = (vc_q == '1) ? vc_q : vc_q + 11'd1;
      line_bad  = hs_start && (hc_inc != H_TOTAL_C);
      frame_bad = vs_start && (vc_inc != V_TOTAL_C);

      // hc_d/vc_d are the coordinates of the pixel currently in p_q
      p_d       = mon.pix_in;
      hs_prev_d = hs_a;
      line_vs_d = hs_start ? vs_a : line_vs_q;
      hc_d      = hs_start ? '0 : hc_inc;
      if (!hs_start)     vc_d = vc_q;
      else if (vs_start) vc_d = '0;
      else               vc_d = vc_inc;
      hc_sat = (hc_d == '1);
      active = (hc_d >= HA_FIRST) && (hc_d <= HA_LAST) &&
               (vc_d >= VA_FIRST) && (vc_d <= VA_LAST);

      state_d       = state_q;
      line_ok_d     = line_ok_q;
      locked_d      = locked_q;
      frame_done_d  = 1'b0;
      frame_crc_d   = frame_crc_q;
      frame_count_d = frame_count_q;
      h_len_d       = hs_start ? hc_inc : h_len_q;
      v_len_d       = v_len_q;
      err_d         = mon.err_clr ? '0 : err_q;
      crc_restart   = 1'b0;

      case (state_q)
         SEARCH: begin
            if (vs_start) begin
               state_d     = MEASURE;
               line_ok_d   = 1'b1;
               crc_restart = 1'b1;
            end
         end
         MEASURE: begin
            if (line_bad || hc_sat) line_ok_d = 1'b0;
            if (vs_start) begin
               v_len_d     = vc_inc;
               crc_restart = 1'b1;
               line_ok_d   = 1'b1;
               if (!frame_bad && line_ok_q && !line_bad) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (line_bad || frame_bad || hc_sat) begin
               state_d  = SEARCH;
               locked_d = 1'b0;
               err_d[0] = 1'b1;
            end else if (vs_start) begin
               v_len_d       = vc_inc;
               frame_crc_d   = crc_q;
               frame_count_d = frame_count_q + 16'd1;
               frame_done_d  = 1'b1;
               crc_restart   = 1'b1;
            end
         end
         default: begin
            state_d  = SEARCH;
            locked_d = 1'b0;
         end
      endcase

`ifdef MON_BLANK_CHECK_EN
      if (state_q == LOCKED && !active && rgb != '0) err_d[1] = 1'b1;
`else
      err_d[1] = 1'b0;
`endif

      // restart and first-byte update share a cycle so a frame's first pixel is never dropped
      crc_base = crc_restart ? 16'hFFFF : crc_q;
      crc_d    = active ? crc16_byte(crc_base, {2'b00, rgb}) : crc_base;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= SEARCH;
         p_q           <= 8'h88;
         hs_prev_q     <= 1'b0;
         line_vs_q     <= 1'b0;
         hc_q          <= '0;
         vc_q          <= '0;
         line_ok_q     <= 1'b0;
         crc_q         <= 16'hFFFF;
         locked_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_crc_q   <= '0;
         frame_count_q <= '0;
         h_len_q       <= '0;
         v_len_q       <= '0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         p_q           <= p_d;
         hs_prev_q     <= hs_prev_d;
         line_vs_q     <= line_vs_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         line_ok_q     <= line_ok_d;
         crc_q         <= crc_d;
         locked_q      <= locked_d;
         frame_done_q  <= frame_done_d;
         frame_crc_q   <= frame_crc_d;
         frame_count_q <= frame_count_d;
         h_len_q       <= h_len_d;
         v_len_q       <= v_len_d;
         err_q         <= err_d;
      end
   end

   assign mon.locked      = locked_q;
   assign mon.frame_done  = frame_done_q;
   assign mon.frame_crc   = frame_crc_q;
   assign mon.frame_count = frame_count_q;
   assign mon.h_len       = h_len_q;
   assign mon.v_len       = v_len_q;
   assign mon.err         = err_q;
endmodule

// File: tb/tb_tinyvga_frame_monitor.sv
// Bench for tinyvga_frame_monitor on a 14x7 raster: random/patterned frames against a frame-level model.
// Compile with MON_BLANK_CHECK_EN to match an RTL build that has the blank check enabled.
module tb_tinyvga_frame_monitor;
   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
`ifdef MON_BLANK_CHECK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif
   localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

   logic clk = 1'b0;
   logic rst_n;

   tinyvga_frame_monitor_if mon_if ();

   tinyvga_frame_monitor #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (mon_if)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   int          m_st;
   bit          m_ok;
   logic [1:0]  m_err;
   logic [15:0] m_count;
   logic [15:0] m_last_crc;
   logic [15:0] exp_crc_q[$];
   logic [15:0] exp_cnt_q[$];
   logic [15:0] zero_crc;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [7:0] enc(input logic [5:0] b, input bit hs_act, input bit vs_act);
      logic [7:0] v;
      v[7] = ~hs_act; v[3] = ~vs_act;
      v[0] = b[5]; v[4] = b[4];
      v[1] = b[3]; v[5] = b[2];
      v[2] = b[1]; v[6] = b[0];
      return v;
   endfunction

   task automatic drive(input logic [7:0] pix, input logic clr, input logic rst);
      @(posedge clk); #1;
      mon_if.pix_in  = pix;
      mon_if.err_clr = clr;
      rst_n          = ~rst;
   endtask

   task automatic check_reset();
      check("rst_locked", mon_if.locked, 0);
      check("rst_frame_done", mon_if.frame_done, 0);
      check("rst_frame_crc", mon_if.frame_crc, 0);
      check("rst_frame_count", mon_if.frame_count, 0);
      check("rst_h_len", mon_if.h_len, 0);
      check("rst_v_len", mon_if.v_len, 0);
      check("rst_err", mon_if.err, 0);
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check({tag, "_locked"}, mon_if.locked, (m_st == M_LOCKED) ? 1 : 0);
      check({tag, "_err"}, mon_if.err, m_err);
      check({tag, "_count"}, mon_if.frame_count, m_count);
   endtask

   task automatic model_reset();
      m_st    = M_SEARCH;
      m_ok    = 1'b0;
      m_err   = '0;
      m_count = '0;
      exp_crc_q.delete();
      exp_cnt_q.delete();
   endtask

   task automatic model_frame_start();
      case (m_st)
         M_SEARCH: begin m_st = M_MEASURE; m_ok = 1'b1; end
         M_MEASURE: begin
            if (m_ok) m_st = M_LOCKED;
            m_ok = 1'b1;
         end
         default: begin
            m_count = m_count + 16'd1;
            exp_crc_q.push_back(m_last_crc);
            exp_cnt_q.push_back(m_count);
         end
      endcase
   endtask

   task automatic model_line_start(input int y, input int short_line, input int clr_line);
      if (y == clr_line) m_err = '0;
      if (short_line >= 0 && y == short_line + 1) begin
         if (m_st == M_LOCKED) begin
            m_st     = M_SEARCH;
            m_err[0] = 1'b1;
         end else if (m_st == M_MEASURE) begin
            m_ok = 1'b0;
         end
      end
   endtask

   // mode: 0 zero RGB, 1 x+8*y pattern, 2 random; negative line numbers disable that feature
   task automatic send_frame(input int mode, input int short_line, input int clr_line,
                             input int blank_line, input int rst_line);
      logic [15:0] c;
      logic [5:0]  b;
      int          len;
      bit          act, clr, rst;
      c = 16'hFFFF;
      for (int y = 0; y < VT; y++) begin
         if (y == 0) model_frame_start();
         else        model_line_start(y, short_line, clr_line);
         len = (y == short_line) ? HT - 1 : HT;
         for (int x = 0; x < len; x++) begin
            act = (x >= HS + HB) && (x < HS + HB + HA) && (y >= VS + VB) && (y < VS + VB + VA);
            b = '0;
            if (act) begin
               case (mode)
                  0:       b = '0;
                  1:       b = 6'((x - (HS + HB)) + 8 * (y - (VS + VB)));
                  default: b = 6'($urandom);
               endcase
               c = crc_ref(c, {2'b00, b});
            end else if (y == blank_line && x >= HS + HB + HA) begin
               b = 6'b110000;
               if (m_st == M_LOCKED && BLANK_EN) m_err[1] = 1'b1;
            end
            rst = (y == rst_line) && (x == 6 || x == 7);
            clr = (y == clr_line) && (x == 1);
            drive(enc(b, (x < HS), (y < VS)), clr, rst);
            if (rst && x == 7) begin
               model_reset();
               @(negedge clk);
               check_reset();
            end
         end
      end
      m_last_crc = c;
   endtask

   always @(negedge clk) begin
      if (mon_if.frame_done === 1'b1) begin
         if (exp_crc_q.size() == 0) begin
            check("unexpected_frame_done", mon_if.frame_done, 0);
         end else begin
            check("frame_crc", mon_if.frame_crc, exp_crc_q.pop_front());
            check("frame_count_at_done", mon_if.frame_count, exp_cnt_q.pop_front());
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      mon_if.pix_in  = 8'h88;
      mon_if.err_clr = 1'b0;
      model_reset();
      m_last_crc = 16'hFFFF;
      zero_crc   = 16'hFFFF;
      for (int i = 0; i < HA * VA; i++) zero_crc = crc_ref(zero_crc, 8'h00);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // clean zero frames: lock after frame 1, frame_done at end of frames 2 and 3
      send_frame(0, -1, -1, -1, -1); check_status("t1_f1");
      send_frame(0, -1, -1, -1, -1); check_status("t1_f2");
      send_frame(0, -1, -1, -1, -1); check_status("t1_f3");
      send_frame(0, -1, -1, -1, -1); check_status("t1_f4");
      check("t1_count_two", mon_if.frame_count, 2);
      check("t1_zero_crc", mon_if.frame_crc, zero_crc);
      check("t1_h_len", mon_if.h_len, HT);
      check("t1_v_len", mon_if.v_len, VT);

      // patterned then random pixel frames
      for (int i = 0; i < 3; i++) begin send_frame(1, -1, -1, -1, -1); check_status("t2_pat"); end
      for (int i = 0; i < 4; i++) begin send_frame(2, -1, -1, -1, -1); check_status("t2_rnd"); end

      // short line while locked, then relock
      send_frame(2, 3, -1, -1, -1); check_status("t3_short");
      send_frame(2, -1, -1, -1, -1); check_status("t3_meas");
      send_frame(2, -1, -1, -1, -1); check_status("t3_relock");
      check("t3_h_len", mon_if.h_len, HT);

      // err_clr alone, then err_clr coinciding with a fault
      send_frame(2, -1, 3, -1, -1); check_status("t4_clr");
      send_frame(2, 2, 3, -1, -1);  check_status("t4_clr_fault");
      send_frame(2, -1, -1, -1, -1); check_status("t4_meas");
      send_frame(2, -1, -1, -1, -1); check_status("t4_relock");

      // RGB in front porch while locked
      send_frame(2, -1, -1, 2, -1); check_status("t5_blank");
      send_frame(2, -1, -1, -1, -1); check_status("t5_after");

      // reset mid-frame, then full relock
      send_frame(2, -1, -1, -1, 3); check_status("t6_rst");
      for (int i = 0; i < 4; i++) begin send_frame(2, -1, -1, -1, -1); check_status("t6_relock"); end
      check("t6_count", mon_if.frame_count, 2);

      repeat (4) @(negedge clk);
      check("pending_frame_done", exp_crc_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
